// File: rtl/msk_rcon_sched.sv
// rtl/msk_rcon_sched.sv - masked round-constant scheduler (share-0 constant add, LFSR constants, round count)
// Optional input bypass port enabled by defining MSKRCON_BYPASS_EN.
module msk_rcon_sched #(
   parameter int d = 2,
   parameter int count = 4,
   parameter int NROUNDS = 3,
   parameter logic [count-1:0] RCON_INIT = 4'b0001,
   parameter logic [count-1:0] RCON_POLY = 4'b0011,
   localparam int RW = $clog2(NROUNDS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [count*d-1:0]   in_data,
`ifdef MSKRCON_BYPASS_EN
   input  logic                 in_bypass,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [count*d-1:0]   out_data,
   output logic [RW-1:0]        round,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [RW-1:0] ROUND_MAX  = RW'(NROUNDS);
   localparam logic [RW-1:0] ROUND_LAST = RW'(NROUNDS - 1);

   state_t               state, state_next;
   logic [count-1:0]     rcon;
   logic [count-1:0]     rcon_next;
   logic [count*d-1:0]   xform;
   logic                 bypass;
   logic                 accept;
   logic                 step;

`ifdef MSKRCON_BYPASS_EN
   assign bypass = in_bypass;
`else
   assign bypass = 1'b0;
`endif

   assign in_ready = (state == RUN) & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign step     = accept & ~bypass;
   assign busy     = (state != IDLE);

   assign rcon_next = {rcon[count-2:0], 1'b0} ^ (rcon[count-1] ? RCON_POLY : '0);

   // Only share 0 of each bit sees the constant; other shares pass straight through.
   always_comb begin
      xform = in_data;
      if (!bypass) begin
         for (int i = 0; i < count; i++) begin
            xform[i*d] = in_data[i*d] ^ rcon[i];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (step && round == ROUND_LAST) state_next = DRAIN;
         DRAIN:   if (out_valid && out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rcon      <= RCON_INIT;
         round     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
      end else begin
         done <= (state == DRAIN) & out_valid & out_ready;
         if (state == IDLE && start) begin
            rcon  <= RCON_INIT;
            round <= '0;
         end
         if (step) begin
            rcon <= rcon_next;
            if (round != ROUND_MAX) round <= round + 1'b1;
         end
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= xform;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_msk_rcon_sched.sv
// tb/tb_msk_rcon_sched.sv - directed self-checking bench for msk_rcon_sched
// Bypass steps are compiled in when MSKRCON_BYPASS_EN is defined.
module tb_msk_rcon_sched;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, out_ready, in_bypass;
   logic [7:0] in_data;
   logic       in_ready, out_valid, busy, done;
   logic [7:0] out_data;
   logic [1:0] round;

   logic       start5, in_valid5;
   logic       in_ready5, out_valid5, busy5, done5;
   logic [7:0] out_data5;
   logic [2:0] round5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msk_rcon_sched dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data),
`ifdef MSKRCON_BYPASS_EN
      .in_bypass(in_bypass),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .round(round), .busy(busy), .done(done)
   );

   msk_rcon_sched #(.NROUNDS(5)) dut5 (
      .clk(clk), .rst(rst), .start(start5), .in_valid(in_valid5), .in_ready(in_ready5),
      .in_data(8'h00),
`ifdef MSKRCON_BYPASS_EN
      .in_bypass(1'b0),
`endif
      .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5),
      .round(round5), .busy(busy5), .done(done5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_bypass = 1'b0;
      in_data = 8'h00; start5 = 1'b0; in_valid5 = 1'b0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_round", round, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      // run 1: zero words, free-flowing output
      rst = 1'b0; start = 1'b1;
      tick();
      chk("r1_busy", busy, 1);
      chk("r1_in_ready", in_ready, 1);
      start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
      tick();
      chk("r1_w0", out_data, 8'h01);
      chk("r1_ov0", out_valid, 1);
      chk("r1_rnd1", round, 1);
      tick();
      chk("r1_w1", out_data, 8'h04);
      chk("r1_rnd2", round, 2);
      tick();
      chk("r1_w2", out_data, 8'h10);
      chk("r1_rnd3", round, 3);
      chk("r1_drain_in_ready", in_ready, 0);
      chk("r1_drain_busy", busy, 1);
      in_valid = 1'b0;
      tick();
      chk("r1_done", done, 1);
      chk("r1_busy_fall", busy, 0);
      chk("r1_ov_fall", out_valid, 0);
      tick();
      chk("r1_done_1cyc", done, 0);

      // run 2: all-ones words
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
      tick();
      chk("r2_w0", out_data, 8'hFE);
      tick();
      chk("r2_w1", out_data, 8'hFB);
      tick();
      chk("r2_w2", out_data, 8'hEF);
      in_valid = 1'b0;
      tick();
      chk("r2_done", done, 1);
      tick();

      // run 3: backpressure after first accept
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
      tick();
      chk("r3_w0", out_data, 8'h01);
      out_ready = 1'b0;
      #1;
      chk("r3_bp_in_ready", in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("r3_bp_data", out_data, 8'h01);
         chk("r3_bp_valid", out_valid, 1);
         chk("r3_bp_round", round, 1);
      end
      out_ready = 1'b1;
      #1;
      chk("r3_release_in_ready", in_ready, 1);
      tick();
      chk("r3_w1", out_data, 8'h04);
      tick();
      chk("r3_w2", out_data, 8'h10);
      in_valid = 1'b0;
      tick();
      chk("r3_done", done, 1);
      tick();

      // run 4: reset after the second accept, then a fresh run
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1;
      tick();
      tick();
      chk("r4_w1", out_data, 8'h04);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      chk("r4_rst_ov", out_valid, 0);
      chk("r4_rst_data", out_data, 8'h00);
      chk("r4_rst_busy", busy, 0);
      chk("r4_rst_round", round, 0);
      chk("r4_rst_done", done, 0);
      rst = 1'b0;
      tick();
      chk("r4_no_done", done, 0);
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1;
      tick();
      chk("r4_new_w0", out_data, 8'h01);
      tick(); tick();
      in_valid = 1'b0;
      tick();
      chk("r4_new_done", done, 1);
      tick();

      // five-round instance: LFSR wraps to 0011 on the fifth word
      start5 = 1'b1;
      tick();
      start5 = 1'b0; in_valid5 = 1'b1;
      tick();
      chk("n5_w0", out_data5, 8'h01);
      tick();
      chk("n5_w1", out_data5, 8'h04);
      tick();
      chk("n5_w2", out_data5, 8'h10);
      tick();
      chk("n5_w3", out_data5, 8'h40);
      tick();
      chk("n5_w4", out_data5, 8'h05);
      chk("n5_round", round5, 5);
      in_valid5 = 1'b0;
      tick();
      chk("n5_done", done5, 1);
      chk("n5_busy", busy5, 0);
      chk("n5_other_idle", busy, 0);
      tick();

`ifdef MSKRCON_BYPASS_EN
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1; in_bypass = 1'b1; in_data = 8'h00;
      tick();
      chk("bp_w0", out_data, 8'h00);
      chk("bp_round0", round, 0);
      in_bypass = 1'b0;
      tick();
      chk("bp_w1", out_data, 8'h01);
      tick();
      chk("bp_w2", out_data, 8'h04);
      chk("bp_round2", round, 2);
      in_valid = 1'b0;
      tick();
      chk("bp_still_busy", busy, 1);
      chk("bp_no_done", done, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
